// File: rtl/elink_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elink_pkg
// Purpose  : Shared frame width, counter widths and FSM encoding for the
//            e-link transmit arbiter.
// Revision : 1.0  initial release
// ============================================================================
package elink_pkg;

    localparam int FRAME_W     = 76;
    localparam int FRAME_CNT_W = 16;
    localparam int ERR_CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } tx_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/elink_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : elink_tx_arbiter_if
// Purpose  : Requester handshake plus e-link encoder handshake bundle.
// Revision : 1.0  initial release
// ============================================================================
interface elink_tx_arbiter_if #(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0]                   req_valid;
    logic [N_REQ*elink_pkg::FRAME_W-1:0] req_frame;
    logic [N_REQ-1:0]                   req_ack;
    logic [N_REQ-1:0]                   req_done;
    logic [N_REQ-1:0]                   req_err;
    logic                               tx_fifo_pfull;
    logic                               start_write_emulator;
    logic [elink_pkg::FRAME_W-1:0]      data_tra_out;
    logic                               end_write_emulator;

    // master = arbiter side, slave = requesters plus encoder
    modport master (
        input  req_valid, req_frame, tx_fifo_pfull, end_write_emulator,
        output req_ack, req_done, req_err, start_write_emulator, data_tra_out
    );

    modport slave (
        output req_valid, req_frame, tx_fifo_pfull, end_write_emulator,
        input  req_ack, req_done, req_err, start_write_emulator, data_tra_out
    );

endinterface
`default_nettype wire

// File: rtl/elink_tx_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick; search starts after last_gnt.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_gnt,
    output logic [N_REQ-1:0]         gnt_onehot,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     any
);

    localparam int c_IDX_W = $clog2(N_REQ);

    logic               w_found;
    logic [c_IDX_W-1:0] w_pos;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        w_found    = 1'b0;
        w_pos      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_pos = c_IDX_W'((int'(last_gnt) + k) % N_REQ);
            if (!w_found && req[w_pos]) begin
                w_found           = 1'b1;
                gnt_idx           = w_pos;
                gnt_onehot[w_pos] = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule
`default_nettype wire

// File: rtl/elink_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : elink_tx_arbiter
// Purpose  : Shares the e-link transmit path among N_REQ frame requesters
//            with round-robin grants, timeout abort and transfer statistics.
// Revision : 1.0  initial release
// ============================================================================
module elink_tx_arbiter
    import elink_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TIMEOUT    = 1024,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk_40,
    input  logic                     rst,
    elink_tx_arbiter_if.master       bus,
    output logic [$clog2(N_REQ)-1:0] gnt_id,
    output logic                     busy,
    output logic [FRAME_CNT_W-1:0]   frame_cnt,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_TO_W  = $clog2(TIMEOUT);
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_START = START;
    localparam logic [1:0] c_ST_WAIT  = WAIT;
    localparam logic [1:0] c_ST_GAP   = GAP;
    localparam logic [1:0] c_ST_AFTER = (GAP_CYCLES == 0) ? c_ST_IDLE : c_ST_GAP;

    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]             r_state;
    logic [c_IDX_W-1:0]     r_last;
    logic [c_IDX_W-1:0]     r_gnt;
    logic [FRAME_W-1:0]     r_data;
    logic [c_TO_W-1:0]      r_tcnt;
    logic [c_GAP_W-1:0]     r_gcnt;
    logic                   r_start;
    logic [N_REQ-1:0]       r_ack;
    logic [N_REQ-1:0]       r_done;
    logic [N_REQ-1:0]       r_err;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic [ERR_CNT_W-1:0]   r_err_cnt;

    logic [N_REQ-1:0]       w_gnt_onehot;
    logic [c_IDX_W-1:0]     w_gnt_idx;
    logic                   w_any;
    logic [FRAME_W-1:0]     w_frame;
    logic [N_REQ-1:0]       w_own_mask;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req        (bus.req_valid),
        .last_gnt   (r_last),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    assign w_frame    = bus.req_frame[int'(w_gnt_idx)*FRAME_W +: FRAME_W];
    assign w_own_mask = N_REQ'(1) << r_gnt;

    always_ff @(posedge clk_40 or negedge rst) begin
        if (!rst) begin
            r_state     <= c_ST_IDLE;
            r_last      <= c_IDX_W'(N_REQ - 1);
            r_gnt       <= '0;
            r_data      <= '0;
            r_tcnt      <= '0;
            r_gcnt      <= '0;
            r_start     <= 1'b0;
            r_ack       <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_start <= 1'b0;
            r_ack   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    // back-pressure only gates new grants, never an active transfer
                    if (w_any && !bus.tx_fifo_pfull) begin
                        r_data  <= w_frame;
                        r_gnt   <= w_gnt_idx;
                        r_last  <= w_gnt_idx;
                        r_start <= 1'b1;
                        r_ack   <= w_gnt_onehot;
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    r_tcnt  <= '0;
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // completion is checked first so it wins over a coincident timeout
                    if (bus.end_write_emulator) begin
                        r_done      <= w_own_mask;
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                        r_gcnt      <= '0;
                        r_state     <= c_ST_AFTER;
                    end else if (r_tcnt == c_TO_LAST) begin
                        r_err <= w_own_mask;
                        if (r_err_cnt != '1) begin
                            r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        r_gcnt  <= '0;
                        r_state <= c_ST_AFTER;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                c_ST_GAP: begin
                    if (r_gcnt == c_GAP_LAST) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_gcnt <= r_gcnt + 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.start_write_emulator = r_start;
    assign bus.req_ack              = r_ack;
    assign bus.req_done             = r_done;
    assign bus.req_err              = r_err;
    assign bus.data_tra_out         = r_data;
    assign gnt_id                   = r_gnt;
    assign busy                     = (r_state != c_ST_IDLE);
    assign frame_cnt                = r_frame_cnt;
    assign err_cnt                  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_elink_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_elink_tx_arbiter
// Purpose  : Scoreboard bench for elink_tx_arbiter (N_REQ=4, TIMEOUT=16, GAP=2).
// Revision : 1.0  initial release
// ============================================================================
module tb_elink_tx_arbiter;

    typedef struct { int id; logic [75:0] data; } start_t;
    typedef struct { int id; int off; }           evt_t;

    logic        clk_40 = 1'b0;
    logic        rst;
    logic [1:0]  gnt_id;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start_cyc = 0;
    int exp_frames = 0;
    int exp_errs = 0;
    int rem[4];
    int tag[4];
    int exp_tag[4];
    int delay_of[4];

    start_t exp_start[$];
    evt_t   exp_done[$];
    evt_t   exp_err[$];
    start_t mon_s;
    evt_t   mon_e;

    elink_tx_arbiter_if #(.N_REQ(4)) bus ();

    elink_tx_arbiter #(
        .N_REQ      (4),
        .TIMEOUT    (16),
        .GAP_CYCLES (2)
    ) dut (
        .clk_40    (clk_40),
        .rst       (rst),
        .bus       (bus),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk_40 = ~clk_40;
    always @(posedge clk_40) cyc <= cyc + 1;

    function automatic logic [75:0] mk_frame(input int i, input int t);
        return {12'hA00 | 12'(i), 32'(t) ^ 32'h5A5A_0000, 32'hC0DE_0000 | 32'(i)};
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred, none expected", name);
    endtask

    task automatic push_start(input int id);
        start_t s;
        s.id = id;
        s.data = mk_frame(id, exp_tag[id]);
        exp_tag[id]++;
        exp_start.push_back(s);
    endtask

    task automatic push_done(input int id, input int off);
        evt_t e;
        e.id = id;
        e.off = off;
        exp_done.push_back(e);
        exp_frames++;
    endtask

    task automatic push_err(input int id, input int off);
        evt_t e;
        e.id = id;
        e.off = off;
        exp_err.push_back(e);
        exp_errs++;
    endtask

    task automatic check_reset(input string p);
        check({p, "_busy"},      busy, 0);
        check({p, "_gnt_id"},    gnt_id, 0);
        check({p, "_data"},      bus.data_tra_out, 0);
        check({p, "_frame_cnt"}, frame_cnt, 0);
        check({p, "_err_cnt"},   err_cnt, 0);
        check({p, "_start"},     bus.start_write_emulator, 0);
        check({p, "_ack"},       bus.req_ack, 0);
        check({p, "_done"},      bus.req_done, 0);
        check({p, "_err"},       bus.req_err, 0);
    endtask

    task automatic clear_model();
        exp_start.delete();
        exp_done.delete();
        exp_err.delete();
        exp_frames = 0;
        exp_errs = 0;
    endtask

    task automatic do_reset(input string p);
        @(negedge clk_40);
        rst = 1'b0;
        #1 check_reset(p);
        repeat (2) @(negedge clk_40);
        rst = 1'b1;
        clear_model();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk_40);
        while (!(busy == 1'b0 && exp_start.size() == 0 && exp_done.size() == 0
                 && exp_err.size() == 0) && n < 600) begin
            @(negedge clk_40);
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    // requester models: hold valid until acked, advance frame tag per ack
    initial forever begin
        @(negedge clk_40);
        for (int i = 0; i < 4; i++) begin
            if (bus.req_ack[i] && rem[i] > 0) begin
                rem[i]--;
                tag[i]++;
            end
            bus.req_valid[i] = (rem[i] > 0);
            bus.req_frame[i*76 +: 76] = mk_frame(i, tag[i]);
        end
    end

    // encoder model: end pulse delay_of[id] cycles after start, 0 = never
    initial forever begin
        int d;
        @(negedge clk_40);
        if (bus.start_write_emulator) begin
            d = delay_of[gnt_id];
            if (d > 0) begin
                repeat (d) @(negedge clk_40);
                bus.end_write_emulator = 1'b1;
                @(negedge clk_40);
                bus.end_write_emulator = 1'b0;
            end
        end
    end

    // monitor: pops expectations whenever the DUT presents a pulse
    initial forever begin
        @(negedge clk_40);
        if (bus.start_write_emulator) begin
            last_start_cyc = cyc;
            if (exp_start.size() == 0) fail_evt("start_unexpected");
            else begin
                mon_s = exp_start.pop_front();
                check("start_gnt_id", gnt_id, mon_s.id);
                check("start_data", bus.data_tra_out, mon_s.data);
                check("start_ack", bus.req_ack, 4'b0001 << mon_s.id);
            end
        end else if (|bus.req_ack) fail_evt("ack_without_start");
        if (|bus.req_done) begin
            if (exp_done.size() == 0) fail_evt("done_unexpected");
            else begin
                mon_e = exp_done.pop_front();
                check("done_vec", bus.req_done, 4'b0001 << mon_e.id);
                check("done_latency", cyc - last_start_cyc, mon_e.off);
            end
        end
        if (|bus.req_err) begin
            if (exp_err.size() == 0) fail_evt("err_unexpected");
            else begin
                mon_e = exp_err.pop_front();
                check("err_vec", bus.req_err, 4'b0001 << mon_e.id);
                check("err_latency", cyc - last_start_cyc, mon_e.off);
            end
        end
    end

    initial begin
        int n;
        int k;
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_frame = '0;
        bus.tx_fifo_pfull = 1'b0;
        bus.end_write_emulator = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0;
            tag[i] = 0;
            exp_tag[i] = 0;
            delay_of[i] = 10;
        end

        // two sparse requesters: 0 then 2
        do_reset("rst1");
        push_start(0); push_done(0, 11);
        push_start(2); push_done(2, 11);
        rem[0] = 1; rem[2] = 1;
        wait_idle("t1");
        check("t1_frame_cnt", frame_cnt, exp_frames);

        // all four pending, requester 0 twice: order 0,1,2,3,0
        do_reset("rst2");
        for (int i = 0; i < 4; i++) begin
            push_start(i); push_done(i, 11);
        end
        push_start(0); push_done(0, 11);
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        wait_idle("t2");
        check("t2_frame_cnt", frame_cnt, exp_frames);

        // back-pressure holds off the grant; release is sampled by IDLE at the
        // end of the release cycle, so start shows on the second sample
        bus.tx_fifo_pfull = 1'b1;
        rem[1] = 1;
        n = 0;
        repeat (50) begin
            @(negedge clk_40);
            if (bus.start_write_emulator) n++;
        end
        check("t3_no_start_under_pfull", n, 0);
        check("t3_idle_under_pfull", busy, 0);
        push_start(1); push_done(1, 11);
        bus.tx_fifo_pfull = 1'b0;
        k = 1;
        while (!bus.start_write_emulator && k < 10) begin
            @(negedge clk_40);
            k++;
        end
        check("t3_release_latency", k, 2);
        bus.tx_fifo_pfull = 1'b1;
        wait_idle("t3");
        bus.tx_fifo_pfull = 1'b0;
        check("t3_frame_cnt", frame_cnt, exp_frames);

        // requester 2 never ends: error at S+17, then requester 3 served
        delay_of[2] = 0;
        push_start(2); push_err(2, 17);
        push_start(3); push_done(3, 11);
        rem[2] = 1; rem[3] = 1;
        wait_idle("t4");
        check("t4_err_cnt", err_cnt, exp_errs);
        check("t4_frame_cnt", frame_cnt, exp_frames);

        // end arrives on the same cycle the timeout would fire
        delay_of[0] = 16;
        push_start(0); push_done(0, 17);
        rem[0] = 1;
        wait_idle("t5");
        check("t5_err_cnt", err_cnt, exp_errs);
        check("t5_frame_cnt", frame_cnt, exp_frames);

        // reset in the middle of WAIT drops the transfer silently
        delay_of[1] = 0;
        push_start(1);
        rem[1] = 1;
        n = 0;
        while (exp_start.size() != 0 && n < 200) begin
            @(negedge clk_40);
            n++;
        end
        check("t6_start_seen", exp_start.size(), 0);
        repeat (5) @(negedge clk_40);
        check("t6_busy_in_wait", busy, 1);
        rst = 1'b0;
        #1 check_reset("t6_async");
        repeat (2) @(negedge clk_40);
        rst = 1'b1;
        clear_model();
        delay_of[0] = 10; delay_of[1] = 10;
        push_start(0); push_done(0, 11);
        push_start(1); push_done(1, 11);
        rem[0] = 1; rem[1] = 1;
        wait_idle("t6");
        check("t6_frame_cnt", frame_cnt, exp_frames);
        check("t6_err_cnt", err_cnt, exp_errs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
